// File: rtl/cla_add32_pkg.sv
// Carry-lookahead helpers shared by the 4-bit block and the 32-bit tree.
// Latency: pure functions, zero cycles.
// Backpressure: none; combinational helpers only.
package cla_add32_pkg;

    // Carries into positions 0..3 of a 4-wide lookahead level, from per-position g/p and a carry-in.
    // Every carry is a flat sum of products, so nothing ripples between positions.
    function automatic logic [3:0] lookahead4(
        input logic [3:0] gi,
        input logic [3:0] pi,
        input logic       cin
    );
        logic [3:0] c;
        c[0] = cin;
        c[1] = gi[0] | (pi[0] & cin);
        c[2] = gi[1] | (pi[1] & gi[0]) | (pi[1] & pi[0] & cin);
        c[3] = gi[2] | (pi[2] & gi[1]) | (pi[2] & pi[1] & gi[0])
             | (pi[2] & pi[1] & pi[0] & cin);
        return c;
    endfunction

    // Group generate of four positions: the group produces a carry-out on its own, whatever its carry-in.
    function automatic logic group_g4(
        input logic [3:0] gi,
        input logic [3:0] pi
    );
        return gi[3] | (pi[3] & gi[2]) | (pi[3] & pi[2] & gi[1])
             | (pi[3] & pi[2] & pi[1] & gi[0]);
    endfunction

endpackage

// File: rtl/cla_add32_gp4.sv
// 4-bit lookahead block: bit p/g, block G/P and sum slice from a carry-in.
// Latency: combinational, zero cycles.
// Backpressure: none; outputs follow inputs.
module cla_gp4
    import cla_add32_pkg::*;
(
    input  logic [3:0] a,
    input  logic [3:0] b,
    input  logic       ci,
    output logic [3:0] s,
    output logic       g,
    output logic       p
);

    logic [3:0] bit_g;
    logic [3:0] bit_p;
    logic [3:0] bit_c;

    // Bit-level propagate/generate, lookahead carries, sum and block G/P.
    always_comb begin
        bit_p = a ^ b;
        bit_g = a & b;
        bit_c = lookahead4(bit_g, bit_p, ci);
        s     = bit_p ^ bit_c;
        g     = group_g4(bit_g, bit_p);
        p     = &bit_p;
    end

endmodule

// File: rtl/cla_add32.sv
// 32-bit carry-lookahead adder: s = a + b + ci (mod 2^32) plus group generate/propagate.
// Latency: combinational, zero cycles; clock/reset do not touch the datapath.
// Backpressure: none; no handshake, outputs follow inputs at all times.
module cla_add32
    import cla_add32_pkg::*;
(
    input  logic        clock,
    input  logic        reset,
    input  logic [31:0] a,
    input  logic [31:0] b,
    input  logic        ci,
    output logic [31:0] s,
    output logic        g,
    output logic        p
);

    localparam int WIDTH = 32;
    localparam int BLK   = 4;
    localparam int NBLK  = WIDTH / BLK;

    logic [NBLK-1:0] blk_g;
    logic [NBLK-1:0] blk_p;
    logic [NBLK-1:0] blk_c;
    logic [1:0]      grp_g;
    logic [1:0]      grp_p;
    logic [1:0]      grp_c;

    // Eight 4-bit blocks; each takes its carry-in from the lookahead tree below.
    for (genvar i = 0; i < NBLK; i++) begin : g_blk
        cla_gp4 u_blk (
            .a  (a[i*BLK +: BLK]),
            .b  (b[i*BLK +: BLK]),
            .ci (blk_c[i]),
            .s  (s[i*BLK +: BLK]),
            .g  (blk_g[i]),
            .p  (blk_p[i])
        );
    end

    // Two-level tree: blocks 0-3 and 4-7 form groups, the top combine joins the groups.
    // Block carry-ins depend only on block G/P and ci, never on a neighbouring block's sum path.
    always_comb begin
        grp_g[0] = group_g4(blk_g[3:0], blk_p[3:0]);
        grp_p[0] = &blk_p[3:0];
        grp_g[1] = group_g4(blk_g[7:4], blk_p[7:4]);
        grp_p[1] = &blk_p[7:4];

        grp_c[0] = ci;
        grp_c[1] = grp_g[0] | (grp_p[0] & ci);

        blk_c[3:0] = lookahead4(blk_g[3:0], blk_p[3:0], grp_c[0]);
        blk_c[7:4] = lookahead4(blk_g[7:4], blk_p[7:4], grp_c[1]);

        g = grp_g[1] | (grp_p[1] & grp_g[0]);
        p = grp_p[1] & grp_p[0];
    end

    // All-propagate means no bit can generate, so g and p are never high together.
    a_gp_exclusive: assert property (@(posedge clock) disable iff (reset) !(g && p));

endmodule

// File: tb/tb_cla_add32.sv
module tb_cla_add32;

    logic        clock = 1'b0;
    logic        reset;
    logic [31:0] a;
    logic [31:0] b;
    logic        ci;
    logic [31:0] s;
    logic        g;
    logic        p;

    typedef struct packed {
        logic [31:0] a;
        logic [31:0] b;
        logic        ci;
        logic [31:0] s;
        logic        g;
        logic        p;
    } exp_t;

    exp_t sb_q[$];
    int   n_cmp = 0;
    int   n_err = 0;
    logic drv_vld = 1'b0;

    always #4 clock = ~clock;

    cla_add32 dut (
        .clock (clock),
        .reset (reset),
        .a     (a),
        .b     (b),
        .ci    (ci),
        .s     (s),
        .g     (g),
        .p     (p)
    );

    // Drive one vector just after the rising edge and record what the outputs must be.
    task automatic issue(input logic rst, input logic [31:0] va, input logic [31:0] vb,
                         input logic vci, input logic [31:0] es, input logic eg, input logic ep);
        exp_t e;
        @(posedge clock);
        #1;
        reset   = rst;
        a       = va;
        b       = vb;
        ci      = vci;
        drv_vld = 1'b1;
        e.a = va; e.b = vb; e.ci = vci; e.s = es; e.g = eg; e.p = ep;
        sb_q.push_back(e);
    endtask

    // Monitor: on every falling edge with a vector presented, pop and compare.
    initial begin
        exp_t e;
        forever begin
            @(negedge clock);
            if (drv_vld) begin
                n_cmp++;
                if (sb_q.size() == 0) begin
                    n_err++;
                    $display("FAIL sb_underflow: output presented with no expectation queued");
                end else begin
                    e = sb_q.pop_front();
                    if (s !== e.s || g !== e.g || p !== e.p) begin
                        n_err++;
                        $display("FAIL vec a=%h b=%h ci=%b rst=%b: got s=%h g=%b p=%b, want s=%h g=%b p=%b",
                                 e.a, e.b, e.ci, reset, s, g, p, e.s, e.g, e.p);
                    end
                end
            end
        end
    end

    initial begin
        #500us;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [31:0] va;
        logic [31:0] vb;
        logic        vci;
        logic        vrst;
        logic [32:0] sum33;
        logic [32:0] sum33_nc;

        reset = 1'b1;
        a     = '0;
        b     = '0;
        ci    = 1'b0;

        // Reset asserted: outputs must still follow inputs.
        issue(1'b1, 32'h0000_0000, 32'h0000_0000, 1'b0, 32'h0000_0000, 1'b0, 1'b0);
        issue(1'b1, 32'h0000_0001, 32'h0000_0001, 1'b0, 32'h0000_0002, 1'b0, 1'b0);
        issue(1'b1, 32'hFFFF_FFFF, 32'h0000_0000, 1'b1, 32'h0000_0000, 1'b0, 1'b1);
        // Normal operation, directed vectors.
        issue(1'b0, 32'h0000_0000, 32'h0000_0000, 1'b0, 32'h0000_0000, 1'b0, 1'b0);
        issue(1'b0, 32'h0000_0001, 32'h0000_0001, 1'b0, 32'h0000_0002, 1'b0, 1'b0);
        issue(1'b0, 32'h0000_0002, 32'h0000_0002, 1'b0, 32'h0000_0004, 1'b0, 1'b0);
        issue(1'b0, 32'hFFFF_FFFE, 32'h0000_0001, 1'b0, 32'hFFFF_FFFF, 1'b0, 1'b1);
        issue(1'b0, 32'hFFFF_FFFF, 32'h0000_0001, 1'b0, 32'h0000_0000, 1'b1, 1'b0);
        issue(1'b0, 32'hFFFF_FFFF, 32'h0000_0000, 1'b1, 32'h0000_0000, 1'b0, 1'b1);
        issue(1'b0, 32'hFFFF_0000, 32'h0000_FFFF, 1'b0, 32'hFFFF_FFFF, 1'b0, 1'b1);
        issue(1'b0, 32'hFFFF_0000, 32'h0000_FFFF, 1'b1, 32'h0000_0000, 1'b0, 1'b1);
        issue(1'b0, 32'hFFFF_0001, 32'h0000_FFFF, 1'b0, 32'h0000_0000, 1'b1, 1'b0);
        issue(1'b0, 32'hFFFF_0001, 32'h0000_FFFF, 1'b1, 32'h0000_0001, 1'b1, 1'b0);
        issue(1'b0, 32'h8000_0000, 32'h8000_0000, 1'b0, 32'h0000_0000, 1'b1, 1'b0);
        issue(1'b0, 32'h1234_5678, 32'h9ABC_DEF0, 1'b0, 32'hACF1_3568, 1'b0, 1'b0);
        issue(1'b0, 32'h1234_5678, 32'h9ABC_DEF0, 1'b1, 32'hACF1_3569, 1'b0, 1'b0);
        issue(1'b0, 32'h0000_000F, 32'h0000_0001, 1'b0, 32'h0000_0010, 1'b0, 1'b0);
        issue(1'b0, 32'h7FFF_FFFF, 32'h0000_0001, 1'b0, 32'h8000_0000, 1'b0, 1'b0);
        issue(1'b0, 32'h0000_FFFF, 32'h0000_0000, 1'b1, 32'h0001_0000, 1'b0, 1'b0);
        // Reset pulse mid-stream has no effect.
        issue(1'b1, 32'hFFFF_0001, 32'h0000_FFFF, 1'b1, 32'h0000_0001, 1'b1, 1'b0);
        issue(1'b0, 32'h0F0F_0F0F, 32'hF0F0_F0F0, 1'b1, 32'h0000_0000, 1'b0, 1'b1);

        // Random vectors against an arithmetic reference.
        for (int i = 0; i < 10000; i++) begin
            va   = $urandom;
            vb   = ($urandom_range(0, 7) == 0) ? ~va : $urandom;
            vci  = 1'($urandom_range(0, 1));
            vrst = ($urandom_range(0, 15) == 0);
            sum33    = {1'b0, va} + {1'b0, vb} + {32'b0, vci};
            sum33_nc = {1'b0, va} + {1'b0, vb};
            issue(vrst, va, vb, vci, sum33[31:0],
                  sum33_nc > 33'h0_FFFF_FFFF, (va ^ vb) == 32'hFFFF_FFFF);
        end

        @(posedge clock);
        #1;
        drv_vld = 1'b0;
        repeat (2) @(posedge clock);

        n_cmp++;
        if (sb_q.size() != 0) begin
            n_err++;
            $display("FAIL sb_drain: %0d expectations left, want 0", sb_q.size());
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
